// File: rtl/reg_bank_shift_pkg.sv
// Shared defaults for the MAC datapath register bank: memory geometry and reset level.
package reg_bank_shift_pkg;

    localparam int   MEM_WIDTH    = 8;
    localparam int   MEM_DEPTH    = 4;
    localparam logic RESET_ACTIVE = 1'b0;

endpackage

// File: rtl/reg_bank_shift_wide_register.sv
// Enabled WIDTH-bit storage cell with synchronous active-low reset; one per bank entry.
module wide_register
    import reg_bank_shift_pkg::*;
#(
    parameter int WIDTH = MEM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset == RESET_ACTIVE) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bank_shift.sv
// Register bank with one write port, two registered read ports and a delay-line shift mode.
module reg_bank_shift
    import reg_bank_shift_pkg::*;
#(
    parameter int WIDTH = MEM_WIDTH,
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] shift_in,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic [WIDTH-1:0] shift_out,
    output logic [DEPTH-1:0] valid
);

    logic [WIDTH-1:0] w_entry [DEPTH];
    logic [WIDTH-1:0] w_next  [DEPTH];
    logic [DEPTH-1:0] w_en;
    logic [DEPTH-1:0] w_valid_next;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    logic [WIDTH-1:0] r_rd_a;
    logic [WIDTH-1:0] r_rd_b;
    logic [WIDTH-1:0] r_shift_out;
    logic [DEPTH-1:0] r_valid;

    // Next state: shift first, then a write overrides its single target entry.
    always_comb begin
        w_valid_next = r_valid;
        w_en         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_next[i] = w_entry[i];
        end
        if (shift_en) begin
            w_next[0]    = shift_in;
            w_valid_next = {r_valid[DEPTH-2:0], 1'b1};
            w_en         = '1;
            for (int i = 1; i < DEPTH; i++) begin
                w_next[i] = w_entry[i-1];
            end
        end
        if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == i[AW-1:0]) begin
                    w_next[i]       = wr_data;
                    w_valid_next[i] = 1'b1;
                    w_en[i]         = 1'b1;
                end
            end
        end
    end

    // Reads see the post-shift, post-write state; unmatched addresses fall through to 0.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == i[AW-1:0]) begin
                w_rd_a = w_next[i];
            end
            if (rd_addr_b == i[AW-1:0]) begin
                w_rd_b = w_next[i];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        wide_register #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .enable(w_en[g]),
            .d     (w_next[g]),
            .q     (w_entry[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset == RESET_ACTIVE) begin
            r_rd_a      <= '0;
            r_rd_b      <= '0;
            r_shift_out <= '0;
            r_valid     <= '0;
        end else begin
            r_rd_a  <= w_rd_a;
            r_rd_b  <= w_rd_b;
            r_valid <= w_valid_next;
            if (shift_en) begin
                r_shift_out <= w_entry[DEPTH-1];
            end
        end
    end

    assign rd_data_a = r_rd_a;
    assign rd_data_b = r_rd_b;
    assign shift_out = r_shift_out;
    assign valid     = r_valid;

endmodule

// File: tb/tb_reg_bank_shift.sv
// Scoreboard bench: a DEPTH=4 and a DEPTH=3 bank share stimulus and are checked against an array model.
module tb_reg_bank_shift;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       shift_en;
    logic [7:0] shift_in;
    logic [1:0] rd_addr_a;
    logic [1:0] rd_addr_b;

    logic [7:0] rd_a4, rd_b4, so4;
    logic [3:0] valid4;
    logic [7:0] rd_a3, rd_b3, so3;
    logic [2:0] valid3;

    typedef struct packed {
        logic [7:0] rd_a;
        logic [7:0] rd_b;
        logic [7:0] so;
        logic [3:0] valid;
    } exp_t;

    exp_t sb4[$];
    exp_t sb3[$];
    exp_t me4, me3;

    int checks = 0;
    int errors = 0;

    // Behavioural model: index k=0 is the DEPTH=4 bank, k=1 the DEPTH=3 bank.
    logic [7:0] mdl_mem [2][4];
    logic       mdl_v   [2][4];
    logic [7:0] mdl_so  [2];

    always #5 clk = ~clk;

    reg_bank_shift #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .shift_en(shift_en), .shift_in(shift_in), .rd_addr_a(rd_addr_a), .rd_data_a(rd_a4),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_b4), .shift_out(so4), .valid(valid4)
    );

    reg_bank_shift #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .shift_en(shift_en), .shift_in(shift_in), .rd_addr_a(rd_addr_a), .rd_data_a(rd_a3),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_b3), .shift_out(so3), .valid(valid3)
    );

    function automatic int depth_of(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    task automatic model_step(input int k, output exp_t e);
        int d;
        d = depth_of(k);
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                mdl_mem[k][i] = 8'h00;
                mdl_v[k][i]   = 1'b0;
            end
            mdl_so[k] = 8'h00;
        end else begin
            if (shift_en) begin
                mdl_so[k] = mdl_mem[k][d-1];
                for (int i = d - 1; i > 0; i--) begin
                    mdl_mem[k][i] = mdl_mem[k][i-1];
                    mdl_v[k][i]   = mdl_v[k][i-1];
                end
                mdl_mem[k][0] = shift_in;
                mdl_v[k][0]   = 1'b1;
            end
            if (wr_en && int'(wr_addr) < d) begin
                mdl_mem[k][wr_addr] = wr_data;
                mdl_v[k][wr_addr]   = 1'b1;
            end
        end
        e.rd_a  = (reset && int'(rd_addr_a) < d) ? mdl_mem[k][rd_addr_a] : 8'h00;
        e.rd_b  = (reset && int'(rd_addr_b) < d) ? mdl_mem[k][rd_addr_b] : 8'h00;
        e.so    = mdl_so[k];
        e.valid = 4'b0000;
        for (int i = 0; i < d; i++) begin
            e.valid[i] = mdl_v[k][i];
        end
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; returns #1 after the active edge.
    task automatic cycle(input logic rst, input logic we, input logic [1:0] wa, input logic [7:0] wd,
                         input logic se, input logic [7:0] si, input logic [1:0] ra, input logic [1:0] rb);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        shift_en  = se;
        shift_in  = si;
        rd_addr_a = ra;
        rd_addr_b = rb;
        model_step(0, e);
        sb4.push_back(e);
        model_step(1, e);
        sb3.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb4.size() > 0) begin
            me4 = sb4.pop_front();
            cmp("d4_rd_a", rd_a4, me4.rd_a);
            cmp("d4_rd_b", rd_b4, me4.rd_b);
            cmp("d4_shift_out", so4, me4.so);
            cmp("d4_valid", {4'h0, valid4}, {4'h0, me4.valid});
        end
        if (sb3.size() > 0) begin
            me3 = sb3.pop_front();
            cmp("d3_rd_a", rd_a3, me3.rd_a);
            cmp("d3_rd_b", rd_b3, me3.rd_b);
            cmp("d3_shift_out", so3, me3.so);
            cmp("d3_valid", {5'h00, valid3}, {4'h0, me3.valid});
        end
    end

    initial begin
        logic [7:0] a_vals [5];
        logic [3:0] v_steps [4];
        a_vals  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        v_steps = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        shift_en = 1'b0; shift_in = '0; rd_addr_a = '0; rd_addr_b = '0;

        cycle(0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        cmp("reset_valid", {4'h0, valid4}, 8'h00);
        cmp("reset_rd_a", rd_a4, 8'h00);

        // Fill all entries, then read back
        cycle(1, 1, 0, 8'h11, 0, 8'h00, 2, 3);
        cycle(1, 1, 1, 8'h22, 0, 8'h00, 2, 3);
        cycle(1, 1, 2, 8'h33, 0, 8'h00, 2, 3);
        cycle(1, 1, 3, 8'h44, 0, 8'h00, 2, 3);
        cycle(1, 0, 0, 8'h00, 0, 8'h00, 2, 3);
        cmp("t1_rd_a", rd_a4, 8'h33);
        cmp("t1_rd_b", rd_b4, 8'h44);
        cmp("t1_valid", {4'h0, valid4}, 8'h0F);

        // Delay line from a clean reset
        cycle(0, 0, 0, 8'h00, 0, 8'h00, 0, 3);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 8'h00, 1, a_vals[i], 0, 3);
            if (i < 4) cmp("t2_valid_step", {4'h0, valid4}, {4'h0, v_steps[i]});
        end
        cmp("t2_shift_out", so4, 8'hA1);
        cmp("t2_entry0", rd_a4, 8'hA5);
        cmp("t2_entry3", rd_b4, 8'hA2);

        // Shift and write to entry 0 together: the write wins
        cycle(1, 1, 0, 8'hF0, 1, 8'h0F, 0, 1);
        cmp("t3_rd_a", rd_a4, 8'hF0);
        cmp("t3_rd_b", rd_b4, 8'hA5);

        cycle(1, 1, 1, 8'h5A, 0, 8'h00, 1, 0);
        cmp("t4_rd_a", rd_a4, 8'h5A);

        // Out-of-range write and read on the DEPTH=3 bank
        cycle(1, 1, 3, 8'hFF, 0, 8'h00, 3, 2);
        cmp("t5_rd_a3", rd_a3, 8'h00);
        cmp("t5_valid3", {5'h00, valid3}, 8'h07);
        cycle(1, 0, 0, 8'h00, 0, 8'h00, 3, 3);
        cmp("t5_rd_b3", rd_b3, 8'h00);

        // Reset beats a simultaneous write and shift
        cycle(0, 1, 2, 8'h77, 1, 8'h66, 2, 0);
        cmp("t6_valid", {4'h0, valid4}, 8'h00);
        cmp("t6_rd_a", rd_a4, 8'h00);
        cmp("t6_shift_out", so4, 8'h00);
        cycle(1, 1, 0, 8'h3C, 0, 8'h00, 0, 1);
        cmp("t6_resume_rd_a", rd_a4, 8'h3C);
        cmp("t6_resume_valid", {4'h0, valid4}, 8'h01);

        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        cycle(1, 0, 0, 8'h00, 0, 8'h00, 0, 1);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb4.size() != 0 || sb3.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0", sb4.size(), sb3.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
